// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the FSM state encoding, the default word width and a clog2 helper.
package fifo_write_arbiter_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DATA_W_DEF = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin pick: the first eligible index after last_grant, wrapping mod N_REQ.
// Purely combinational; found is 0 when nothing is eligible.
module fifo_write_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int GID_W = 2
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [GID_W-1:0] last_grant,
    output logic             found,
    output logic [GID_W-1:0] pick
);

    int rank;
    int best_rank;

    // rank 0 is the index right after last_grant; the lowest eligible rank wins
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        rank      = 0;
        best_rank = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            rank = (i + N_REQ - 1 - int'(last_grant)) % N_REQ;
            if (eligible[i] && (rank < best_rank)) begin
                best_rank = rank;
                pick      = GID_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// A granted producer streams up to MAX_BURST beats straight through to the FIFO.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4,
    localparam int GID_W    = clog2(N_REQ)
) (
    input  logic                    clk_write,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_mask,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       fifo_data_in,
    output logic                    fifo_input_valid,
    input  logic                    fifo_input_enable,
    output logic [GID_W-1:0]        grant_id,
    output logic                    busy
);

    // Handshake: a beat moves on the clk_write edge where req_valid[g] and
    // req_ready[g] are both 1. req_ready depends only on the grant and FIFO
    // space, never on req_valid, so producers may raise valid at any time.

    arb_state_e        state, state_nxt;
    logic [GID_W-1:0]  grant_nxt, last_grant, last_nxt, pick;
    logic [7:0]        beat_cnt, cnt_nxt, beat_inc;
    logic              found;
    logic [N_REQ-1:0]  eligible;
    logic [DATA_W-1:0] words [N_REQ];

    assign eligible = req_valid & ~req_mask;
    assign beat_inc = beat_cnt + 8'd1;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            words[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    fifo_write_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .GID_W (GID_W)
    ) u_rr_pick (
        .eligible   (eligible),
        .last_grant (last_grant),
        .found      (found),
        .pick       (pick)
    );

    always_ff @(posedge clk_write or negedge rstn) begin
        if (!rstn) begin
            state      <= ARB;
            grant_id   <= '0;
            last_grant <= GID_W'(N_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_nxt;
            beat_cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        grant_nxt        = grant_id;
        last_nxt         = last_grant;
        cnt_nxt          = beat_cnt;
        req_ready        = '0;
        fifo_data_in     = '0;
        fifo_input_valid = 1'b0;
        busy             = 1'b0;
        unique case (state)
            ARB: begin
                if (found) begin
                    grant_nxt = pick;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                busy                = 1'b1;
                fifo_input_valid    = req_valid[grant_id];
                fifo_data_in        = words[grant_id];
                req_ready[grant_id] = fifo_input_enable;
                // an idle producer gives up its slot without transferring anything
                if (!req_valid[grant_id]) begin
                    state_nxt = ARB;
                    last_nxt  = grant_id;
                    cnt_nxt   = '0;
                end else if (fifo_input_enable) begin
                    cnt_nxt = beat_inc;
                    if (req_last[grant_id] || (beat_inc == 8'(MAX_BURST))) begin
                        state_nxt = ARB;
                        last_nxt  = grant_id;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: state_nxt = ARB;
        endcase
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_fifo_write_arbiter;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int MAXB = 4;
    localparam int GW   = 2;

    logic           clk_write = 1'b0;
    logic           rstn = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_mask = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_input_valid;
    logic           fifo_input_enable = 1'b0;
    logic [GW-1:0]  grant_id;
    logic           busy;

    fifo_write_arbiter #(
        .N_REQ     (N),
        .DATA_W    (W),
        .MAX_BURST (MAXB)
    ) dut (
        .clk_write         (clk_write),
        .rstn              (rstn),
        .req_valid         (req_valid),
        .req_last          (req_last),
        .req_data          (req_data),
        .req_mask          (req_mask),
        .req_ready         (req_ready),
        .fifo_data_in      (fifo_data_in),
        .fifo_input_valid  (fifo_input_valid),
        .fifo_input_enable (fifo_input_enable),
        .grant_id          (grant_id),
        .busy              (busy)
    );

    // clock / reset
    always #5 clk_write = ~clk_write;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model: who owns the port, how many beats it has moved
    int m_owner = -1;
    int m_gid   = 0;
    int m_last  = N - 1;
    int m_beats = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word_of(input int i);
        return req_data[i*W +: W];
    endfunction

    task automatic set_word(input int i, input logic [W-1:0] w);
        req_data[i*W +: W] = w;
    endtask

    task automatic model_check();
        logic         e_busy, e_valid;
        logic [W-1:0] e_data;
        logic [N-1:0] e_ready;
        int           e_gid;
        bit           accept;
        bit           done;
        int           idx;
        e_busy  = 1'b0;
        e_valid = 1'b0;
        e_data  = '0;
        e_ready = '0;
        e_gid   = m_gid;
        accept  = 1'b0;
        if (!rstn) begin
            e_gid = 0;
        end else if (m_owner >= 0) begin
            e_busy           = 1'b1;
            e_valid          = req_valid[m_owner];
            e_data           = word_of(m_owner);
            e_ready[m_owner] = fifo_input_enable;
            accept           = e_valid && fifo_input_enable;
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("grant_id", 32'(grant_id), 32'(e_gid));
        chk("fifo_input_valid", 32'(fifo_input_valid), 32'(e_valid));
        chk("fifo_data_in", 32'(fifo_data_in), 32'(e_data));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        // scoreboard of words the FIFO must receive, in order
        if (accept) exp_q.push_back(e_data);
        if (fifo_input_valid && fifo_input_enable) begin
            if (exp_q.size() == 0) chk("fifo_write_expected", 32'(exp_q.size()), 32'd1);
            else chk("fifo_write_word", 32'(fifo_data_in), 32'(exp_q.pop_front()));
        end
        // advance the model by one clock
        if (!rstn) begin
            m_owner = -1; m_gid = 0; m_last = N - 1; m_beats = 0;
        end else if (m_owner < 0) begin
            done = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (!done && req_valid[idx] && !req_mask[idx]) begin
                    m_owner = idx; m_gid = idx; m_beats = 0; done = 1'b1;
                end
            end
        end else if (!req_valid[m_owner]) begin
            m_last = m_owner; m_owner = -1;
        end else if (fifo_input_enable) begin
            m_beats++;
            if (req_last[m_owner] || m_beats == MAXB) begin
                m_last = m_owner; m_owner = -1;
            end
        end
    endtask

    // inputs are driven at posedge+1; outputs checked at posedge+3 or +4
    task automatic tick();
        #2;
        model_check();
        @(posedge clk_write);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = '0; req_last = '0; req_mask = '0; req_data = '0;
        fifo_input_enable = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        @(posedge clk_write);
        #1;
        // reset state
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_fifo_valid", 32'(fifo_input_valid), 32'd0);
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        do_reset();

        // 1: three-beat packet from req0
        req_valid = 4'b0001; set_word(0, 16'h0001);
        #1; chk("t1_bubble_busy", 32'(busy), 32'd0); tick();
        #1; chk("t1_b1_data", 32'(fifo_data_in), 32'h0001);
        chk("t1_b1_ready", 32'(req_ready), 32'b0001); chk("t1_b1_valid", 32'(fifo_input_valid), 32'd1); tick();
        set_word(0, 16'h0002);
        #1; chk("t1_b2_data", 32'(fifo_data_in), 32'h0002); tick();
        set_word(0, 16'h0003); req_last = 4'b0001;
        #1; chk("t1_b3_data", 32'(fifo_data_in), 32'h0003); tick();
        req_valid = '0; req_last = '0;
        #1; chk("t1_released", 32'(busy), 32'd0); tick();

        // 2: everyone valid, no last: 4-beat bursts in order 0,1,2,3,0
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            for (int i = 0; i < N; i++) set_word(i, 16'(16'hA000 + i * 256 + c));
            #1;
            chk("t2_busy", 32'(busy), 32'((c % 5) != 0));
            if ((c % 5) != 0) chk("t2_grant", 32'(grant_id), 32'((c / 5) % 4));
            tick();
        end

        // 3: FIFO full for 5 cycles after beat 2 of req1
        do_reset();
        req_valid = 4'b0010; set_word(1, 16'h1101);
        tick();
        #1; chk("t3_b1", 32'(fifo_data_in), 32'h1101); tick();
        set_word(1, 16'h1102);
        #1; chk("t3_b2", 32'(fifo_data_in), 32'h1102); tick();
        set_word(1, 16'h1103); fifo_input_enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_full_ready", 32'(req_ready), 32'd0);
            chk("t3_full_busy", 32'(busy), 32'd1);
            tick();
        end
        fifo_input_enable = 1'b1;
        #1; chk("t3_b3", 32'(fifo_data_in), 32'h1103); chk("t3_b3_ready", 32'(req_ready), 32'b0010); tick();
        set_word(1, 16'h1104);
        #1; chk("t3_b4", 32'(fifo_data_in), 32'h1104); tick();
        req_valid = '0;
        #1; chk("t3_released", 32'(busy), 32'd0); tick();

        // 4: req1 masked, only req2 ever served
        req_mask = 4'b0010; req_valid = 4'b0110;
        for (int c = 0; c < 12; c++) begin
            set_word(1, 16'(16'h4100 + c)); set_word(2, 16'(16'h4200 + c));
            #1;
            chk("t4_req1_ready", 32'(req_ready[1]), 32'd0);
            chk("t4_busy", 32'(busy), 32'((c % 5) != 0));
            if (busy) chk("t4_grant", 32'(grant_id), 32'd2);
            tick();
        end

        // 5: reset at beat 2 of a req2 burst
        do_reset();
        req_valid = 4'b0100; set_word(2, 16'h5201);
        tick(); tick();
        set_word(2, 16'h5202);
        #1; chk("t5_b2", 32'(fifo_data_in), 32'h5202);
        rstn = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(fifo_input_valid), 32'd0);
        chk("t5_rst_data", 32'(fifo_data_in), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        tick();
        rstn = 1'b1; req_valid = 4'b1111;
        #1; chk("t5_bubble", 32'(busy), 32'd0); tick();
        #1; chk("t5_first_grant", 32'(grant_id), 32'd0); chk("t5_first_busy", 32'(busy), 32'd1); tick();

        // 6: req3 goes idle after one beat while req0 waits
        do_reset();
        req_valid = 4'b1000; set_word(3, 16'h6301);
        tick();
        #1; chk("t6_b1_grant", 32'(grant_id), 32'd3); tick();
        req_valid = 4'b0001; set_word(0, 16'h6001);
        #1; chk("t6_idle_valid", 32'(fifo_input_valid), 32'd0); chk("t6_idle_ready", 32'(req_ready), 32'b1000); tick();
        #1; chk("t6_arb", 32'(busy), 32'd0); tick();
        #1; chk("t6_next_grant", 32'(grant_id), 32'd0); chk("t6_next_busy", 32'(busy), 32'd1); tick();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rstn = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) req_mask = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 8);
                req_last[i]  = ($urandom_range(0, 4) == 0);
                set_word(i, 16'($urandom));
            end
            fifo_input_enable = ($urandom_range(0, 3) != 0);
            tick();
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
